prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 160 ++++++++++++++++
 tb/tb_prog_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: host byte loader for the CPU program RAM.
// The host talks a 4-phase strobe/ack handshake. Bytes drive a small command
// FSM (LOAD / RUN / HALT) that writes a framed payload into program RAM.
// Optional feature macro: PROG_LOADER_CHECKSUM_EN adds a trailing checksum
// byte to LOAD frames (CSUM state) that is compared against the running sum.
module prog_loader (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] host_data,
   input  logic       host_strobe,
   output logic       host_ack,
   output logic       mem_we,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_wdata,
   output logic       cpu_run,
   output logic       busy,
   output logic       err
);

   localparam logic [7:0] CMD_LOAD = 8'hA5;
   localparam logic [7:0] CMD_RUN  = 8'h5A;
   localparam logic [7:0] CMD_HALT = 8'h3C;

`ifdef PROG_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {IDLE, ADDR, COUNT, DATA, CSUM} state_t;
`else
   typedef enum logic [2:0] {IDLE, ADDR, COUNT, DATA} state_t;
`endif

   state_t     state, state_d;
   logic       sync1, sync2, sync_prev;
   logic       cap;
   logic [7:0] addr_q, addr_d;
   logic [7:0] cnt_q, cnt_d;
   logic       err_d, run_d, we_d;
   logic [7:0] maddr_d, wdata_d;
`ifdef PROG_LOADER_CHECKSUM_EN
   logic [7:0] sum_q, sum_d;
`endif

   // Strobe synchronizer plus edge history; all flops reset high so a strobe
   // already high at reset release is not mistaken for a new byte.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1     <= 1'b1;
         sync2     <= 1'b1;
         sync_prev <= 1'b1;
      end else begin
         sync1     <= host_strobe;
         sync2     <= sync1;
         sync_prev <= sync2;
      end
   end

   assign cap  = sync2 & ~sync_prev;
   assign busy = (state != IDLE);

   // Ack rises on capture and drops once the host has released the strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)        host_ack <= 1'b0;
      else if (cap)   host_ack <= 1'b1;
      else if (!sync2) host_ack <= 1'b0;
   end

   // FSM and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         addr_q    <= 8'h00;
         cnt_q     <= 8'h00;
         err       <= 1'b0;
         cpu_run   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= 8'h00;
         mem_wdata <= 8'h00;
`ifdef PROG_LOADER_CHECKSUM_EN
         sum_q     <= 8'h00;
`endif
      end else begin
         state     <= state_d;
         addr_q    <= addr_d;
         cnt_q     <= cnt_d;
         err       <= err_d;
         cpu_run   <= run_d;
         mem_we    <= we_d;
         mem_addr  <= maddr_d;
         mem_wdata <= wdata_d;
`ifdef PROG_LOADER_CHECKSUM_EN
         sum_q     <= sum_d;
`endif
      end
   end

   // Next-state: one transition per captured byte; everything holds otherwise.
   always_comb begin
      state_d = state;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      err_d   = err;
      run_d   = cpu_run;
      we_d    = 1'b0;
      maddr_d = mem_addr;
      wdata_d = mem_wdata;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_d   = sum_q;
`endif
      if (cap) begin
         case (state)
            IDLE: begin
               case (host_data)
                  CMD_LOAD: begin
                     // Loading under a running core is refused.
                     if (cpu_run) err_d = 1'b1;
                     else begin
                        err_d   = 1'b0;
                        state_d = ADDR;
`ifdef PROG_LOADER_CHECKSUM_EN
                        sum_d   = 8'h00;
`endif
                     end
                  end
                  CMD_RUN:  begin run_d = 1'b1; err_d = 1'b0; end
                  CMD_HALT: begin run_d = 1'b0; err_d = 1'b0; end
                  default:  err_d = 1'b1;
               endcase
            end
            ADDR: begin
               addr_d  = host_data;
               state_d = COUNT;
            end
            COUNT: begin
               // 0x00 means 256: decrementing from 0 wraps to 0xFF naturally.
               cnt_d   = host_data;
               state_d = DATA;
            end
            DATA: begin
               we_d    = 1'b1;
               maddr_d = addr_q;
               wdata_d = host_data;
               addr_d  = addr_q + 8'd1;
               cnt_d   = cnt_q - 8'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
               sum_d   = sum_q + host_data;
               if (cnt_q == 8'd1) state_d = CSUM;
`else
               if (cnt_q == 8'd1) state_d = IDLE;
`endif
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            CSUM: begin
               if (host_data != sum_q) err_d = 1'b1;
               state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized + directed bench for prog_loader with a
// frame-level reference model; set PROG_LOADER_CHECKSUM_EN to match the RTL.
module tb_prog_loader;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] host_data;
   logic       host_strobe;
   logic       host_ack, mem_we, cpu_run, busy, err;
   logic [7:0] mem_addr, mem_wdata;

   prog_loader dut (
      .clk(clk), .rst(rst), .host_data(host_data), .host_strobe(host_strobe),
      .host_ack(host_ack), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .cpu_run(cpu_run), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {logic [7:0] a; logic [7:0] d;} wr_t;

   int  checks = 0;
   int  errors = 0;
   wr_t exp_q[$];
   wr_t obs_q[$];

   // Reference model: frame position in bytes, plus flags.
   bit  m_run, m_err;
   int  m_pos;            // 0 idle, 1 expect addr, 2 expect count, 3 data, 4 checksum
   int  m_addr, m_left, m_sum;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_run = 0; m_err = 0; m_pos = 0; m_addr = 0; m_left = 0; m_sum = 0;
   endtask

   task automatic model(input logic [7:0] b);
      case (m_pos)
         0: begin
            if (b == 8'hA5) begin
               if (m_run) m_err = 1;
               else begin m_err = 0; m_pos = 1; m_sum = 0; end
            end else if (b == 8'h5A) begin m_run = 1; m_err = 0; end
            else if (b == 8'h3C) begin m_run = 0; m_err = 0; end
            else m_err = 1;
         end
         1: begin m_addr = b; m_pos = 2; end
         2: begin m_left = (b == 0) ? 256 : b; m_pos = 3; end
         3: begin
            exp_q.push_back('{a: 8'(m_addr), d: b});
            m_addr = (m_addr + 1) % 256;
            m_sum  = (m_sum + b) % 256;
            m_left--;
`ifdef PROG_LOADER_CHECKSUM_EN
            if (m_left == 0) m_pos = 4;
`else
            if (m_left == 0) m_pos = 0;
`endif
         end
         default: begin
            if (b != 8'(m_sum)) m_err = 1;
            m_pos = 0;
         end
      endcase
   endtask

   // Every write pulse must match the next expected write, one pulse per byte.
   always @(negedge clk) begin
      wr_t e;
      if (!rst && mem_we) begin
         if (exp_q.size() == 0) chk("spurious_we", mem_we, 1'b0);
         else begin
            e = exp_q.pop_front();
            chk("we_addr", mem_addr, e.a);
            chk("we_data", mem_wdata, e.d);
            obs_q.push_back('{a: mem_addr, d: mem_wdata});
         end
      end
   end

   // One full 4-phase handshake, then compare status against the model.
   task automatic send(input logic [7:0] b);
      int n;
      model(b);
      host_data = b;
      @(negedge clk);
      host_strobe = 1'b1;
      n = 0;
      while (host_ack !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      chk("ack_rise", host_ack, 1'b1);
      host_strobe = 1'b0;
      n = 0;
      while (host_ack !== 1'b0 && n < 20) begin @(negedge clk); n++; end
      chk("ack_fall", host_ack, 1'b0);
      repeat (2) @(negedge clk);
      chk("cpu_run", cpu_run, m_run);
      chk("err", err, m_err);
      chk("busy", busy, m_pos != 0);
   endtask

   task automatic check_reset_vals();
      chk("rst_ack", host_ack, 1'b0);
      chk("rst_we", mem_we, 1'b0);
      chk("rst_addr", mem_addr, 8'h00);
      chk("rst_wdata", mem_wdata, 8'h00);
      chk("rst_run", cpu_run, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_err", err, 1'b0);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_vals();
      model_reset();
      exp_q.delete();
      rst = 1'b0;
      @(negedge clk);
   endtask

   // Sends a LOAD frame with the given payload; csum_ok chooses a good or bad checksum.
   task automatic send_frame(input logic [7:0] addr, input logic [7:0] data[$], input bit csum_ok);
      logic [7:0] s;
      s = 8'h00;
      send(8'hA5);
      send(addr);
      send(8'(data.size()));
      foreach (data[i]) begin send(data[i]); s = s + data[i]; end
`ifdef PROG_LOADER_CHECKSUM_EN
      send(csum_ok ? s : ~s);
`else
      if (!csum_ok) send(8'h77);   // junk byte in IDLE instead
`endif
   endtask

   initial begin
      logic [7:0] d[$];
      int n;
      rst = 1'b1; host_strobe = 1'b0; host_data = 8'h00;
      model_reset();
      repeat (3) @(negedge clk);
      check_reset_vals();
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Basic frame at 0x10.
      obs_q.delete();
      d = '{8'h11, 8'h22, 8'h33};
      send_frame(8'h10, d, 1'b1);
      chk("f1_nwr", obs_q.size(), 3);
      if (obs_q.size() == 3) begin
         chk("f1_a0", obs_q[0].a, 8'h10); chk("f1_d0", obs_q[0].d, 8'h11);
         chk("f1_a2", obs_q[2].a, 8'h12); chk("f1_d2", obs_q[2].d, 8'h33);
      end
      chk("f1_err", err, 1'b0);
      chk("f1_busy", busy, 1'b0);

      // Address wrap FE -> FF -> 00.
      obs_q.delete();
      d = '{8'h01, 8'h02, 8'h03};
      send_frame(8'hFE, d, 1'b1);
      chk("f2_nwr", obs_q.size(), 3);
      if (obs_q.size() == 3) begin
         chk("f2_a1", obs_q[1].a, 8'hFF);
         chk("f2_a2", obs_q[2].a, 8'h00); chk("f2_d2", obs_q[2].d, 8'h03);
      end
      chk("f2_err", err, 1'b0);

`ifdef PROG_LOADER_CHECKSUM_EN
      // Wrong checksum: writes kept, err set; HALT clears it.
      obs_q.delete();
      send(8'hA5); send(8'h40); send(8'h02); send(8'hAA); send(8'hBB); send(8'h00);
      chk("f3_nwr", obs_q.size(), 2);
      chk("f3_err", err, 1'b1);
      send(8'h3C);
      chk("f3_clr", err, 1'b0);
`endif

      // LOAD refused while running.
      obs_q.delete();
      send(8'h5A); send(8'hA5);
      chk("run_load_run", cpu_run, 1'b1);
      chk("run_load_err", err, 1'b1);
      chk("run_load_nwr", obs_q.size(), 0);
      send(8'h3C);
      chk("halt_run", cpu_run, 1'b0);

      // Reset after the second of four data bytes.
      obs_q.delete();
      send(8'hA5); send(8'h80); send(8'h04); send(8'hC1); send(8'hC2);
      pulse_reset();
      repeat (8) @(negedge clk);
      chk("abort_nwr", obs_q.size(), 2);
      d = '{8'h5C};
      send_frame(8'h90, d, 1'b1);
      chk("abort_nwr2", obs_q.size(), 3);
      if (obs_q.size() == 3) chk("abort_a", obs_q[2].a, 8'h90);

      // Strobe held high through reset release.
      host_data = 8'hA5;
      host_strobe = 1'b1;
      @(negedge clk); rst = 1'b1;
      repeat (3) @(negedge clk);
      model_reset();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("held_ack", host_ack, 1'b0);
         chk("held_busy", busy, 1'b0);
      end
      host_strobe = 1'b0;
      repeat (4) @(negedge clk);
      send(8'h5A);
      chk("held_run", cpu_run, 1'b1);
      send(8'h3C);

      // Count 0x00 = 256 bytes.
      obs_q.delete();
      send(8'hA5); send(8'h00); send(8'h00);
      n = 0;
      for (int i = 0; i < 256; i++) begin send(8'(i * 7)); n = n + i * 7; end
`ifdef PROG_LOADER_CHECKSUM_EN
      send(8'(n));
`endif
      chk("c256_nwr", obs_q.size(), 256);
      chk("c256_busy", busy, 1'b0);

      // Randomized traffic.
      for (int it = 0; it < 40; it++) begin
         case ($urandom_range(0, 3))
            0: send(8'($urandom));
            1: send(($urandom_range(0, 1) != 0) ? 8'h5A : 8'h3C);
            default: begin
               if (m_pos == 0 && m_run) send(8'h3C);
               d.delete();
               n = $urandom_range(1, 6);
               for (int k = 0; k < n; k++) d.push_back(8'($urandom));
               send_frame(8'($urandom), d, $urandom_range(0, 3) != 0);
            end
         endcase
      end

      repeat (4) @(negedge clk);
      chk("exp_q_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
